// File: rtl/unsign_divider_sched.sv
// Two-requester round-robin scheduler in front of one shared iterative
// restoring divider (one quotient bit per RUN cycle, MSB first).
//
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   req_a, dividend_a, divider_a     requester A handshake and operands
//   req_b, dividend_b, divider_b     requester B handshake and operands
//   gnt_a, gnt_b                     one-cycle pulse: operands captured
//   busy                             state is not IDLE
//   done                             one-cycle pulse: result outputs valid
//   owner                            requester of the result (0=A, 1=B)
//   quotient, remainder, div_zero    registered result, held until next load
module unsign_divider_sched #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic [WIDTH-1:0] dividend_a,
    input  logic [WIDTH-1:0] divider_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] dividend_b,
    input  logic [WIDTH-1:0] divider_b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             busy,
    output logic             done,
    output logic             owner,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    // Datapath state: partial remainder, dividend/quotient shift register,
    // captured divisor, zero-divisor flag, step counter, ownership.
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] aq_q;
    logic [WIDTH-1:0] dvs_q;
    logic             zero_q;
    logic [CNT_W-1:0] cnt_q;
    logic             cur_owner_q;
    logic             last_owner_q;

    logic             pick_a, pick_b, capture;
    logic [WIDTH-1:0] sel_dividend, sel_divider;
    logic [WIDTH:0]   rem_shift, rem_sub, rem_step;
    logic             step_ok;
    logic [WIDTH-1:0] aq_step;
    logic             finish;

    logic             gnt_a_d, gnt_b_d, busy_d, done_d;
    logic [WIDTH-1:0] quotient_d, remainder_d;

    // Round-robin arbitration; requests only count while IDLE.
    // last_owner_q = 1 means B was served last, so A wins a tie.
    always_comb begin : arbitrate
        pick_a = 1'b0;
        pick_b = 1'b0;
        if (state == IDLE) begin
            pick_a = req_a && (!req_b || last_owner_q);
            pick_b = req_b && !(req_a && last_owner_q);
        end
    end

    assign capture      = pick_a | pick_b;
    assign sel_dividend = pick_b ? dividend_b : dividend_a;
    assign sel_divider  = pick_b ? divider_b  : divider_a;

    // One restoring step: shift next dividend bit in, subtract if it fits.
    // The stored remainder is always below the divisor, so the top bit of
    // rem_q is zero and is dropped by the shift.
    always_comb begin : div_step
        rem_shift = (WIDTH+1)'({rem_q, aq_q[WIDTH-1]});
        step_ok   = (rem_shift >= {1'b0, dvs_q});
        rem_sub   = rem_shift - {1'b0, dvs_q};
        rem_step  = step_ok ? rem_sub : rem_shift;
        aq_step   = (aq_q << 1) | WIDTH'(step_ok);
    end

    assign finish = (state == RUN) && (zero_q || (cnt_q == LAST_STEP));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A zero divisor passes through RUN for one cycle only.
    always_comb begin : next_state
        state_next = state;
        case (state)
            IDLE:    if (capture) state_next = RUN;
            RUN:     if (finish)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic: next values for the registered outputs.
    always_comb begin : outputs
        gnt_a_d     = 1'b0;
        gnt_b_d     = 1'b0;
        done_d      = 1'b0;
        busy_d      = 1'b0;
        quotient_d  = aq_step;
        remainder_d = rem_step[WIDTH-1:0];
        if (state == IDLE) begin
            gnt_a_d = pick_a;
            gnt_b_d = pick_b;
        end
        if (finish) begin
            done_d = 1'b1;
        end
        if (zero_q) begin
            quotient_d  = '1;
            remainder_d = aq_q;
        end
        busy_d = (state_next != IDLE);
    end

    // Output and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_a        <= 1'b0;
            gnt_b        <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            owner        <= 1'b0;
            quotient     <= '0;
            remainder    <= '0;
            div_zero     <= 1'b0;
            rem_q        <= '0;
            aq_q         <= '0;
            dvs_q        <= '0;
            zero_q       <= 1'b0;
            cnt_q        <= '0;
            cur_owner_q  <= 1'b0;
            last_owner_q <= 1'b1;
        end else begin
            gnt_a <= gnt_a_d;
            gnt_b <= gnt_b_d;
            busy  <= busy_d;
            done  <= done_d;
            if (capture) begin
                rem_q        <= '0;
                aq_q         <= sel_dividend;
                dvs_q        <= sel_divider;
                zero_q       <= (sel_divider == '0);
                cnt_q        <= '0;
                cur_owner_q  <= pick_b;
                last_owner_q <= pick_b;
            end else if ((state == RUN) && !zero_q) begin
                rem_q <= rem_step;
                aq_q  <= aq_step;
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (finish) begin
                quotient  <= quotient_d;
                remainder <= remainder_d;
                owner     <= cur_owner_q;
                div_zero  <= zero_q;
            end
        end
    end

endmodule

// File: tb/tb_unsign_divider_sched.sv
// Self-checking bench for unsign_divider_sched (WIDTH=8): expected results are
// queued when a request is driven and compared when done pulses.
module tb_unsign_divider_sched;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_a = 1'b0, req_b = 1'b0;
    logic [W-1:0] dividend_a = '0, divider_a = '0;
    logic [W-1:0] dividend_b = '0, divider_b = '0;
    logic         gnt_a, gnt_b, busy, done, owner, div_zero;
    logic [W-1:0] quotient, remainder;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_gnt_cyc  = 0;
    int last_done_cyc = 0;
    logic prev_done = 1'b0;

    typedef struct {
        logic         own;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           lat;
    } exp_t;

    exp_t exp_q[$];

    unsign_divider_sched #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_a      (req_a),
        .dividend_a (dividend_a),
        .divider_a  (divider_a),
        .req_b      (req_b),
        .dividend_b (dividend_b),
        .divider_b  (divider_b),
        .gnt_a      (gnt_a),
        .gnt_b      (gnt_b),
        .busy       (busy),
        .done       (done),
        .owner      (owner),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_zero   (div_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic own, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.own = own;
        if (b == 0) begin
            e.q = '1; e.r = a; e.dz = 1'b1; e.lat = 1;
        end else begin
            e.q = a / b; e.r = a % b; e.dz = 1'b0; e.lat = W;
        end
        return e;
    endfunction

    // Scoreboard monitor: grant ownership/exclusivity and result checking.
    always @(negedge clk) begin
        if (!rst) begin
            if (gnt_a || gnt_b) begin
                total++;
                if ((gnt_a && gnt_b) || done || exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL grant_event: gnt_a=%0b gnt_b=%0b done=%0b queued=%0d", gnt_a, gnt_b, done, exp_q.size());
                end else if (gnt_b !== exp_q[0].own) begin
                    bad++;
                    $display("FAIL grant_owner: got gnt_b=%0b want %0b", gnt_b, exp_q[0].own);
                end
                last_gnt_cyc = cyc;
            end
            if (done) begin
                total++;
                if (prev_done) begin
                    bad++;
                    $display("FAIL done_width: done high two cycles");
                end else if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_done: q=%0d r=%0d", quotient, remainder);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (quotient !== e.q || remainder !== e.r || owner !== e.own ||
                        div_zero !== e.dz || (cyc - last_gnt_cyc) != e.lat) begin
                        bad++;
                        $display("FAIL result: got q=%0d r=%0d own=%0b dz=%0b lat=%0d want q=%0d r=%0d own=%0b dz=%0b lat=%0d",
                                 quotient, remainder, owner, div_zero, cyc - last_gnt_cyc,
                                 e.q, e.r, e.own, e.dz, e.lat);
                    end
                end
                last_done_cyc = cyc;
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    // Raise one request, wait (bounded) for its grant, drop req in the grant cycle.
    task automatic drive_request(input logic side, input logic [W-1:0] dvd, input logic [W-1:0] dvs);
        bit seen = 0;
        if (side) begin req_b = 1'b1; dividend_b = dvd; divider_b = dvs; end
        else      begin req_a = 1'b1; dividend_a = dvd; divider_a = dvs; end
        exp_q.push_back(model(side, dvd, dvs));
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (side ? gnt_b : gnt_a) begin seen = 1; break; end
        end
        if (side) req_b = 1'b0; else req_a = 1'b0;
        if (!seen) begin
            total++; bad++;
            $display("FAIL grant_timeout: side=%0b no grant", side);
        end
    endtask

    task automatic drain(input string name);
        bit ok = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) begin ok = 1; break; end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s_drain: pending=%0d busy=%0b", name, exp_q.size(), busy);
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req_a = 1'($urandom); req_b = 1'($urandom);
            dividend_a = W'($urandom); divider_a = W'($urandom);
            dividend_b = W'($urandom); divider_b = W'($urandom);
            @(negedge clk);
            total++;
            if ({gnt_a, gnt_b, busy, done, owner, quotient, remainder, div_zero} !== '0) begin
                bad++;
                $display("FAIL reset_outputs: gnt=%0b%0b busy=%0b done=%0b q=%0d r=%0d",
                         gnt_a, gnt_b, busy, done, quotient, remainder);
            end
        end
        req_a = 1'b0; req_b = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (busy !== 1'b0) begin
                bad++;
                $display("FAIL idle_busy: got %0b want 0", busy);
            end
        end
    endtask

    task automatic test_round_robin();
        int a_cyc = 0;
        bit ok = 0;
        int n = 0;
        req_a = 1'b1; dividend_a = 8'd255; divider_a = 8'd5;
        req_b = 1'b1; dividend_b = 8'd69;  divider_b = 8'd42;
        exp_q.push_back(model(1'b0, 8'd255, 8'd5));
        exp_q.push_back(model(1'b1, 8'd69, 8'd42));
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (gnt_a) begin ok = 1; a_cyc = cyc; break; end
        end
        req_a = 1'b0;
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (gnt_b) begin ok = 1; break; end
        end
        req_b = 1'b0;
        total++;
        if (!ok || cyc != a_cyc + W + 2) begin
            bad++;
            $display("FAIL rr_b_grant: got cycle %0d want %0d", cyc, a_cyc + W + 2);
        end
        drain("rr_tie");
        // Both held continuously: grants must alternate A, B, A.
        req_a = 1'b1; dividend_a = 8'd100; divider_a = 8'd7;
        req_b = 1'b1; dividend_b = 8'd200; divider_b = 8'd9;
        exp_q.push_back(model(1'b0, 8'd100, 8'd7));
        exp_q.push_back(model(1'b1, 8'd200, 8'd9));
        exp_q.push_back(model(1'b0, 8'd100, 8'd7));
        for (int i = 0; i < 80 && n < 3; i++) begin
            @(negedge clk);
            if (gnt_a || gnt_b) n++;
        end
        req_a = 1'b0; req_b = 1'b0;
        total++;
        if (n != 3) begin
            bad++;
            $display("FAIL rr_alternate: got %0d grants want 3", n);
        end
        drain("rr_alt");
    endtask

    task automatic test_single_a();
        drive_request(1'b0, 8'd13, 8'd2);
        drain("single_a");
        repeat (3) @(negedge clk);
        total++;
        if (quotient !== 8'd6 || remainder !== 8'd1 || owner !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL result_hold: got q=%0d r=%0d own=%0b want q=6 r=1 own=0", quotient, remainder, owner);
        end
    endtask

    task automatic test_div_zero();
        drive_request(1'b1, 8'd77, 8'd0);
        drain("div_zero");
        drive_request(1'b0, 8'd77, 8'd1);
        drain("div_one");
        total++;
        if (div_zero !== 1'b0 || quotient !== 8'd77) begin
            bad++;
            $display("FAIL after_zero: got dz=%0b q=%0d want dz=0 q=77", div_zero, quotient);
        end
    endtask

    task automatic test_boundary();
        int a_cyc;
        bit ok = 0;
        drive_request(1'b0, 8'd3, 8'd200);
        drain("small_dividend");
        // Operands change one cycle after the grant.
        drive_request(1'b0, 8'd100, 8'd7);
        @(posedge clk); #1;
        dividend_a = 8'd250; divider_a = 8'd3;
        drain("operand_change");
        // Request from B raised during RUN waits for the earliest slot.
        drive_request(1'b0, 8'd50, 8'd5);
        a_cyc = cyc;
        req_b = 1'b1; dividend_b = 8'd9; divider_b = 8'd4;
        exp_q.push_back(model(1'b1, 8'd9, 8'd4));
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (gnt_b) begin ok = 1; break; end
        end
        req_b = 1'b0;
        total++;
        if (!ok || cyc != a_cyc + W + 2) begin
            bad++;
            $display("FAIL held_req: got grant cycle %0d want %0d", cyc, a_cyc + W + 2);
        end
        drain("held_req");
    endtask

    task automatic test_abort();
        int dones = 0;
        drive_request(1'b0, 8'd150, 8'd150);
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({gnt_a, gnt_b, busy, done, owner, quotient, remainder, div_zero} !== '0) begin
            bad++;
            $display("FAIL abort_async: busy=%0b done=%0b q=%0d r=%0d", busy, done, quotient, remainder);
        end
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        total++;
        if (dones != 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_no_done: got %0d dones busy=%0b want 0", dones, busy);
        end
        drive_request(1'b0, 8'd150, 8'd150);
        drain("abort_retry");
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_a();
        test_div_zero();
        test_boundary();
        test_abort();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

endmodule
